// File: rtl/addsub_result_decoder.sv
// Output-side checker for the signed add/sub unit.
// Each accepted transaction is latched. The magnitudes of a, b and res are
// converted to BCD by double-dabble, one bit per cycle. The result and the
// overflow are rederived from the latched operands, and err flags any disagreement.
module addsub_result_decoder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  opcode,
  input  logic [WIDTH-1:0]      res,
  input  logic                  flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  a_sign,
  output logic                  b_sign,
  output logic                  r_sign,
  output logic [4*DIGITS-1:0]   a_bcd,
  output logic [4*DIGITS-1:0]   b_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  ovf,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t state, state_nxt;

  // Latched transaction
  logic signed [WIDTH-1:0] a_q, b_q, res_q;
  logic                    op_q, flag_q;
  logic                    as_q, bs_q, rs_q;

  // Double-dabble working registers
  logic [WIDTH-1:0]  a_mag, b_mag, r_mag;
  logic [BW-1:0]     a_acc, b_acc, r_acc;
  logic [CW-1:0]     cnt;

  logic [BW+WIDTH-1:0] a_step, b_step, r_step;
  logic signed [WIDTH-1:0] exp_res, b_eff;
  logic                exp_ovf, err_calc;
  logic                accept, last_step;

  // Two's complement magnitude as an unsigned value, so the most negative code maps to 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + ONE) : v;
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, mag} left by one
  function automatic logic [BW+WIDTH-1:0] dabble(input logic [BW-1:0] bcd,
                                                 input logic [WIDTH-1:0] mag);
    logic [BW-1:0] t;
    t = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t, mag} << 1;
  endfunction

  assign a_step = dabble(a_acc, a_mag);
  assign b_step = dabble(b_acc, b_mag);
  assign r_step = dabble(r_acc, r_mag);

  // Expected result and overflow from the latched operands, all modulo 2^WIDTH
  assign b_eff    = op_q ? ~b_q : b_q;
  assign exp_res  = op_q ? (a_q - b_q) : (a_q + b_q);
  assign exp_ovf  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (exp_res[WIDTH-1] != a_q[WIDTH-1]);
  assign err_calc = (res_q != exp_res) || (flag_q != exp_ovf);

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == CONV) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the transaction on acceptance, then step the conversion once per CONV cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      op_q   <= 1'b0;
      flag_q <= 1'b0;
      as_q   <= 1'b0;
      bs_q   <= 1'b0;
      rs_q   <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      r_mag  <= '0;
      a_acc  <= '0;
      b_acc  <= '0;
      r_acc  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      res_q  <= res;
      op_q   <= opcode;
      flag_q <= flag;
      as_q   <= a[WIDTH-1];
      bs_q   <= b[WIDTH-1];
      rs_q   <= res[WIDTH-1];
      a_mag  <= magnitude(a);
      b_mag  <= magnitude(b);
      r_mag  <= magnitude(res);
      a_acc  <= '0;
      b_acc  <= '0;
      r_acc  <= '0;
      cnt    <= '0;
    end else if (state == CONV) begin
      a_mag  <= a_step[WIDTH-1:0];
      b_mag  <= b_step[WIDTH-1:0];
      r_mag  <= r_step[WIDTH-1:0];
      a_acc  <= a_step[BW+WIDTH-1:WIDTH];
      b_acc  <= b_step[BW+WIDTH-1:WIDTH];
      r_acc  <= r_step[BW+WIDTH-1:WIDTH];
      cnt    <= cnt + CW'(1);
    end
  end

  // Publish results on the final step; they hold until the next transaction completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      r_sign <= 1'b0;
      a_bcd  <= '0;
      b_bcd  <= '0;
      r_bcd  <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else if (last_step) begin
      a_sign <= as_q;
      b_sign <= bs_q;
      r_sign <= rs_q;
      a_bcd  <= a_step[BW+WIDTH-1:WIDTH];
      b_bcd  <= b_step[BW+WIDTH-1:WIDTH];
      r_bcd  <= r_step[BW+WIDTH-1:WIDTH];
      ovf    <= flag_q;
      err    <= err_calc;
    end
  end

endmodule

// File: tb/tb_addsub_result_decoder.sv
// Randomized and directed bench for addsub_result_decoder.
// Expected values come from an integer-arithmetic model of the decoder.
module tb_addsub_result_decoder;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  a, b, res;
  logic        opcode, flag;
  logic        out_valid, out_ready;
  logic        a_sign, b_sign, r_sign;
  logic [11:0] a_bcd, b_bcd, r_bcd;
  logic        ovf, err;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_result_decoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .res(res), .flag(flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_sign(a_sign), .b_sign(b_sign), .r_sign(r_sign),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .r_bcd(r_bcd),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal magnitude of a signed byte, packed as three BCD digits
  function automatic logic [11:0] ref_bcd(input logic [7:0] v);
    int s, m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    return 12'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  // Correct unit output for given operands, as a plain integer computation
  task automatic ref_unit(input logic [7:0] ta, input logic [7:0] tb_, input logic top,
                          output logic [7:0] eres, output logic eovf);
    int sa, sb, e;
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    e  = top ? (sa - sb) : (sa + sb);
    eovf = (e > 127) || (e < -128);
    eres = e[7:0];
  endtask

  task automatic drive_garbage();
    a = 8'($urandom); b = 8'($urandom); res = 8'($urandom);
    opcode = 1'($urandom); flag = 1'($urandom);
  endtask

  // One full transaction: accept, exact latency, result check, backpressure, release
  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_, input logic top,
                         input logic [7:0] tres, input logic tflag, input int hold);
    logic [7:0] eres;
    logic       eovf, eerr;
    ref_unit(ta, tb_, top, eres, eovf);
    eerr = (tres != eres) || (tflag != eovf);

    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb_; opcode = top; res = tres; flag = tflag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_garbage();
    check("in_ready_conv", in_ready, 0);
    for (int i = 1; i < WIDTH; i++) begin
      check("out_valid_early", out_valid, 0);
      @(posedge clk); #1;
    end
    check("out_valid_early", out_valid, 0);
    @(posedge clk); #1;
    check("out_valid_latency", out_valid, 1);
    check("a_sign", a_sign, ta[7]);
    check("b_sign", b_sign, tb_[7]);
    check("r_sign", r_sign, tres[7]);
    check("a_bcd", a_bcd, ref_bcd(ta));
    check("b_bcd", b_bcd, ref_bcd(tb_));
    check("r_bcd", r_bcd, ref_bcd(tres));
    check("ovf", ovf, tflag);
    check("err", err, eerr);

    for (int h = 0; h < hold; h++) begin
      drive_garbage();
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_r_bcd", r_bcd, ref_bcd(tres));
      check("hold_a_bcd", a_bcd, ref_bcd(ta));
      check("hold_err", err, eerr);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_r_bcd", r_bcd, ref_bcd(tres));
    check("release_err", err, eerr);
  endtask

  initial begin
    logic [7:0] ra, rb, rr, eres;
    logic       rop, rf, eovf;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; res = '0; opcode = 1'b0; flag = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", {a_bcd, b_bcd, r_bcd}, 0);
    check("rst_flags", {a_sign, b_sign, r_sign, ovf, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(8'd50,  8'd10,  1'b1, 8'd40,  1'b0, 0);
    run_txn(8'h96,  8'd1,   1'b0, 8'h97,  1'b0, 1);
    run_txn(8'd100, 8'h8C,  1'b1, 8'hD8,  1'b1, 0);
    run_txn(8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 2);
    run_txn(8'd5,   8'd10,  1'b1, 8'h00,  1'b0, 5);

    // Abort during conversion; the transaction must vanish
    check("pre_abort_err", err, 1);
    a = 8'd7; b = 8'd3; opcode = 1'b0; res = 8'd10; flag = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_bcd", {a_bcd, b_bcd, r_bcd}, 0);
    check("abort_flags", {a_sign, b_sign, r_sign, ovf, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 0);
    end

    for (int t = 0; t < 40; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 1'($urandom);
      ref_unit(ra, rb, rop, eres, eovf);
      rr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : eres;
      rf = ($urandom_range(0, 3) == 0) ? ~eovf : eovf;
      run_txn(ra, rb, rop, rr, rf, int'($urandom_range(0, 3)));
    end
    run_txn(8'h7F, 8'h81, 1'b1, 8'hFE, 1'b1, 0);
    run_txn(8'h00, 8'h80, 1'b1, 8'h80, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
